// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy_dot game blocks.
// Contents:
//   state_t         - game session state
//   BCD_W           - width of one BCD digit
//   *_DEF constants - default column geometry used by score_keeper
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int unsigned BCD_W           = 4;

    localparam int unsigned COL_BASE_DEF    = 32;
    localparam int unsigned COL_PITCH_DEF   = 32;
    localparam int unsigned PASS_OFFSET_DEF = 2;

endpackage

// File: rtl/bcd_counter.sv
// Saturating multi-digit BCD counter.
// Ports:
//   dot_clk   - clock, rising edge
//   reset     - synchronous active-high, clears value
//   clear     - synchronous clear
//   inc       - add one (ignored once every digit is 9)
//   value     - BCD count, digit 0 in bits [3:0]
//   saturated - high while every digit is 9
module bcd_counter
    import flappy_pkg::*;
#(
    parameter int unsigned DIGITS = 3
) (
    input  logic                      dot_clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      inc,
    output logic [BCD_W*DIGITS-1:0]   value,
    output logic                      saturated
);

    logic [BCD_W*DIGITS-1:0] value_inc;
    logic                    carry;

    always_comb begin
        saturated = 1'b1;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (value[d*BCD_W +: BCD_W] != 4'd9) begin
                saturated = 1'b0;
            end
        end
    end

    // Ripple a carry from digit 0 upward; a digit at 9 wraps to 0.
    always_comb begin
        value_inc = value;
        carry     = 1'b1;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (value[d*BCD_W +: BCD_W] == 4'd9) begin
                    value_inc[d*BCD_W +: BCD_W] = 4'd0;
                end else begin
                    value_inc[d*BCD_W +: BCD_W] = value[d*BCD_W +: BCD_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge dot_clk) begin
        if (reset || clear) begin
            value <= '0;
        end else if (inc && !saturated) begin
            value <= value_inc;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Game session tracker for flappy_dot: IDLE/PLAY/OVER state, column-pass
// detection, saturating BCD score and high score.
// Ports:
//   dot_clk      - game clock, rising edge
//   reset        - synchronous active-high, clears everything incl. high score
//   dot_x        - current dot x position
//   dot_collided - level, dot has hit an obstacle
//   game_start   - single-cycle request to begin a new game
//   score_bcd    - current score (BCD, digit 0 in [3:0])
//   high_bcd     - best score since reset (BCD)
//   playing      - high while in PLAY
//   game_over    - high while in OVER
//   score_pulse  - one-cycle pulse per counted pass
//   new_high     - one-cycle pulse when high_bcd is updated
module score_keeper
    import flappy_pkg::*;
#(
    parameter int unsigned X_W         = 8,
    parameter int unsigned NUM_COLS    = 4,
    parameter int unsigned COL_BASE    = COL_BASE_DEF,
    parameter int unsigned COL_PITCH   = COL_PITCH_DEF,
    parameter int unsigned PASS_OFFSET = PASS_OFFSET_DEF,
    parameter int unsigned DIGITS      = 3
) (
    input  logic                     dot_clk,
    input  logic                     reset,
    input  logic [X_W-1:0]           dot_x,
    input  logic                     dot_collided,
    input  logic                     game_start,
    output logic [BCD_W*DIGITS-1:0]  score_bcd,
    output logic [BCD_W*DIGITS-1:0]  high_bcd,
    output logic                     playing,
    output logic                     game_over,
    output logic                     score_pulse,
    output logic                     new_high
);

    state_t         state, state_next;
    logic [X_W-1:0] prev_x;
    logic           col_match;
    logic           pass_hit;
    logic           score_clear;
    logic           score_inc;
    logic           score_sat;
    logic           take_high;

    // Pass position of column i, wrapped to X_W bits.
    function automatic logic [X_W-1:0] pass_x(input int unsigned i);
        return X_W'(COL_BASE + i * COL_PITCH + PASS_OFFSET);
    endfunction

    always_comb begin
        col_match = 1'b0;
        for (int unsigned i = 0; i < NUM_COLS; i++) begin
            if (dot_x == pass_x(i)) begin
                col_match = 1'b1;
            end
        end
    end

    // A stationary dot on a pass position counts only once.
    assign pass_hit = col_match && (dot_x != prev_x);

    bcd_counter #(
        .DIGITS (DIGITS)
    ) u_score (
        .dot_clk   (dot_clk),
        .reset     (reset),
        .clear     (score_clear),
        .inc       (score_inc && !score_sat),
        .value     (score_bcd),
        .saturated (score_sat)
    );

    always_ff @(posedge dot_clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        score_clear = 1'b0;
        score_inc   = 1'b0;
        take_high   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (game_start) begin
                    state_next  = ST_PLAY;
                    score_clear = 1'b1;
                end
            end
            ST_PLAY: begin
                if (dot_collided) begin
                    state_next = ST_OVER;
                    // BCD digits are ordered, so a binary compare is a magnitude compare.
                    take_high  = (score_bcd > high_bcd);
                end else if (pass_hit) begin
                    score_inc = 1'b1;
                end
            end
            ST_OVER: begin
                if (game_start) begin
                    state_next  = ST_PLAY;
                    score_clear = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge dot_clk) begin
        if (reset) begin
            prev_x      <= '0;
            high_bcd    <= '0;
            playing     <= 1'b0;
            game_over   <= 1'b0;
            score_pulse <= 1'b0;
            new_high    <= 1'b0;
        end else begin
            prev_x      <= dot_x;
            if (take_high) begin
                high_bcd <= score_bcd;
            end
            playing     <= (state_next == ST_PLAY);
            game_over   <= (state_next == ST_OVER);
            score_pulse <= score_inc;
            new_high    <= take_high;
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: two instances (default geometry and
// a 2-digit / 6-column / pitch-20 variant) share one stimulus stream and are
// compared every cycle against an integer-arithmetic game model.
module tb_score_keeper;

    logic       dot_clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] dot_x = '0;
    logic       dot_collided = 1'b0;
    logic       game_start = 1'b0;

    logic [11:0] score_a, high_a;
    logic        playing_a, game_over_a, score_pulse_a, new_high_a;
    logic [7:0]  score_b, high_b;
    logic        playing_b, game_over_b, score_pulse_b, new_high_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 dot_clk = ~dot_clk;

    score_keeper dut_a (
        .dot_clk      (dot_clk),
        .reset        (reset),
        .dot_x        (dot_x),
        .dot_collided (dot_collided),
        .game_start   (game_start),
        .score_bcd    (score_a),
        .high_bcd     (high_a),
        .playing      (playing_a),
        .game_over    (game_over_a),
        .score_pulse  (score_pulse_a),
        .new_high     (new_high_a)
    );

    score_keeper #(
        .X_W       (8),
        .NUM_COLS  (6),
        .COL_PITCH (20),
        .DIGITS    (2)
    ) dut_b (
        .dot_clk      (dot_clk),
        .reset        (reset),
        .dot_x        (dot_x),
        .dot_collided (dot_collided),
        .game_start   (game_start),
        .score_bcd    (score_b),
        .high_bcd     (high_b),
        .playing      (playing_b),
        .game_over    (game_over_b),
        .score_pulse  (score_pulse_b),
        .new_high     (new_high_b)
    );

    // Reference model: index 0 = dut_a, 1 = dut_b.
    int n_cols [2] = '{4, 6};
    int pitch  [2] = '{32, 20};
    int max_sc [2] = '{999, 99};
    int m_score[2], m_high[2], m_prev[2];
    bit m_play[2], m_over[2], m_pulse[2], m_nh[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          t;
        r = '0;
        t = v;
        for (int d = 0; d < 8; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit on_column(input int k, input int x);
        for (int i = 0; i < n_cols[k]; i++) begin
            if (x == (32 + i * pitch[k] + 2) % 256) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_edge();
        bit hit;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_score[k] = 0; m_high[k] = 0; m_prev[k] = 0;
                m_play[k] = 0; m_over[k] = 0; m_pulse[k] = 0; m_nh[k] = 0;
            end else begin
                hit = on_column(k, int'(dot_x)) && (int'(dot_x) != m_prev[k]);
                m_pulse[k] = 0;
                m_nh[k] = 0;
                if (m_play[k]) begin
                    if (dot_collided) begin
                        m_play[k] = 0;
                        m_over[k] = 1;
                        if (m_score[k] > m_high[k]) begin
                            m_high[k] = m_score[k];
                            m_nh[k] = 1;
                        end
                    end else if (hit) begin
                        m_pulse[k] = 1;
                        if (m_score[k] < max_sc[k]) m_score[k]++;
                    end
                end else if (game_start) begin
                    m_play[k] = 1;
                    m_over[k] = 0;
                    m_score[k] = 0;
                end
                m_prev[k] = int'(dot_x);
            end
        end
    endtask

    task automatic step();
        @(posedge dot_clk);
        model_edge();
        #1;
        check("a.score",     32'(score_a),       to_bcd(m_score[0]));
        check("a.high",      32'(high_a),        to_bcd(m_high[0]));
        check("a.playing",   32'(playing_a),     32'(m_play[0]));
        check("a.game_over", 32'(game_over_a),   32'(m_over[0]));
        check("a.pulse",     32'(score_pulse_a), 32'(m_pulse[0]));
        check("a.new_high",  32'(new_high_a),    32'(m_nh[0]));
        check("b.score",     32'(score_b),       to_bcd(m_score[1]));
        check("b.high",      32'(high_b),        to_bcd(m_high[1]));
        check("b.playing",   32'(playing_b),     32'(m_play[1]));
        check("b.game_over", 32'(game_over_b),   32'(m_over[1]));
        check("b.pulse",     32'(score_pulse_b), 32'(m_pulse[1]));
        check("b.new_high",  32'(new_high_b),    32'(m_nh[1]));
    endtask

    task automatic drive(input logic [7:0] x, input logic c, input logic s, input logic r);
        dot_x        = x;
        dot_collided = c;
        game_start   = s;
        reset        = r;
        step();
    endtask

    task automatic new_game();
        drive(8'd0, 1'b0, 1'b0, 1'b1);
        drive(8'd0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        drive(8'd0, 1'b0, 1'b0, 1'b1);
        drive(8'd0, 1'b0, 1'b0, 1'b1);
        check("reset.score", 32'(score_a), 32'h0);

        // Sweep across all columns.
        drive(8'd0, 1'b0, 1'b1, 1'b0);
        for (int x = 0; x <= 140; x++) drive(8'(x), 1'b0, 1'b0, 1'b0);
        check("sweep.score_a", 32'(score_a), 32'h004);
        check("sweep.score_b", 32'(score_b), 32'h06);
        check("sweep.playing", 32'(playing_a), 32'h1);

        // Holding on a pass position counts once.
        new_game();
        drive(8'd65, 1'b0, 1'b0, 1'b0);
        repeat (5) drive(8'd66, 1'b0, 1'b0, 1'b0);
        check("hold.score_a", 32'(score_a), 32'h001);

        // Collision beats a simultaneous pass; equal score does not raise high.
        for (int g = 0; g < 2; g++) begin
            if (g == 0) new_game(); else drive(8'd0, 1'b0, 1'b1, 1'b0);
            drive(8'd33, 1'b0, 1'b0, 1'b0);
            drive(8'd34, 1'b0, 1'b0, 1'b0);
            drive(8'd66, 1'b0, 1'b0, 1'b0);
            drive(8'd97, 1'b0, 1'b0, 1'b0);
            drive(8'd98, 1'b0, 1'b1, 1'b0);
            drive(8'd130, 1'b1, 1'b0, 1'b0);
            check("collide.high_a", 32'(high_a), 32'h003);
            check("collide.new_high_a", 32'(new_high_a), (g == 0) ? 32'h1 : 32'h0);
            drive(8'd131, 1'b0, 1'b0, 1'b0);
        end

        // Saturation.
        new_game();
        for (int i = 0; i < 1002; i++) begin
            drive(8'd34, 1'b0, 1'b0, 1'b0);
            drive(8'd35, 1'b0, 1'b0, 1'b0);
        end
        check("sat.score_a", 32'(score_a), 32'h999);
        check("sat.score_b", 32'(score_b), 32'h99);
        drive(8'd34, 1'b0, 1'b0, 1'b0);
        check("sat.pulse_a", 32'(score_pulse_a), 32'h1);
        check("sat.pulse_b", 32'(score_pulse_b), 32'h1);
        check("sat.hold_a", 32'(score_a), 32'h999);

        // OVER: score frozen regardless of movement and collisions.
        drive(8'd40, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++)
            drive(8'($urandom_range(0, 150)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("over.score_a", 32'(score_a), 32'h999);
        drive(8'd0, 1'b0, 1'b1, 1'b0);
        check("restart.score_a", 32'(score_a), 32'h000);
        check("restart.playing", 32'(playing_a), 32'h1);

        // Mid-game reset, then passes ignored until game_start.
        for (int x = 0; x <= 100; x++) drive(8'(x), 1'b0, 1'b0, 1'b0);
        drive(8'd101, 1'b0, 1'b0, 1'b1);
        check("midreset.high_a", 32'(high_a), 32'h000);
        for (int x = 0; x <= 140; x++) drive(8'(x), 1'b0, 1'b0, 1'b0);
        check("idle.score_a", 32'(score_a), 32'h000);

        // Randomized play.
        for (int i = 0; i < 3000; i++) begin
            drive(8'($urandom_range(0, 255) < 128 ? $urandom_range(28, 140) : $urandom_range(0, 255)),
                  1'($urandom_range(0, 99) < 4),
                  1'($urandom_range(0, 99) < 6),
                  1'($urandom_range(0, 299) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
